// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and helpers for the 3-stage pipeline hazard
//               controller: FSM state encoding, RV32I base opcodes and the
//               register-source usage decode for each opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Every format except U-type and J-type reads rs1.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    // Only R-, S- and B-type instructions read rs2.
    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Single-operand forwarding compare. Asserts o_fwd when the
//               MEM/WB instruction writes a non-zero rd that matches the
//               EX-stage source register and that source is actually read.
// Ports       : i_wr_en   - MEM/WB writes rd
//               i_rd      - MEM/WB destination index
//               i_rs      - EX-stage source index
//               i_rs_used - EX opcode reads this source
//               i_allow   - forwarding permitted this cycle
//               o_fwd     - select WB result for this operand
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit (
    input  logic       i_wr_en,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_rs,
    input  logic       i_rs_used,
    input  logic       i_allow,
    output logic       o_fwd
);

    // x0 is hard-wired zero, so a write to it never produces a value to forward.
    assign o_fwd = i_allow & i_wr_en & (i_rd != 5'd0) & (i_rd == i_rs) & i_rs_used;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and sequencing controller for the IF | ID/EX | MEM/WB
//               pipeline. Produces stall, flush, PC redirect and forwarding
//               controls, waits on variable-latency data memory with a
//               timeout, and halts the core on a SYSTEM instruction.
// Config      : PIPE_PERF_EN - when defined, cyc_cnt/stall_cnt/flush_cnt are
//               live wrapping counters; otherwise the ports are tied to 0.
// Ports       : clk, rst (async, active-high)
//               opcode_ex, rs1_ex, rs2_ex, br_taken  - EX-stage decode
//               rd_wb, reg_wr_wb, mem_wb             - MEM/WB write info
//               dmem_valid                           - data memory done
//               stall_if, stall_ex, flush_if, pc_sel, wb_kill,
//               fwd_a, fwd_b, mem_err, halted        - pipeline controls
//               cyc_cnt, stall_cnt, flush_cnt        - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_ex,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic             br_taken,
    input  logic [4:0]       rd_wb,
    input  logic             reg_wr_wb,
    input  logic             mem_wb,
    input  logic             dmem_valid,
    output logic             stall_if,
    output logic             stall_ex,
    output logic             flush_if,
    output logic             pc_sel,
    output logic             wb_kill,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                    c_wait_w  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0]   c_timeout = c_wait_w'(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0]   c_one     = c_wait_w'(1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_nxt;
    logic [c_wait_w-1:0]  r_wait_cnt;
    logic [c_wait_w-1:0]  w_wait_nxt;
    logic                 w_stall;
    logic                 w_timeout;
    logic                 w_redirect;
    logic                 w_fwd_allow;

    always_comb begin
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            RUN: begin
                // The RUN cycle that sees the miss is the first stall cycle.
                if (mem_wb && !dmem_valid) begin
                    w_stall     = 1'b1;
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = c_one;
                end
            end
            MEM_WAIT: begin
                if (dmem_valid) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == c_timeout) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_stall    = 1'b1;
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            HALT: begin
                w_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
        // A SYSTEM instruction only retires out of EX on an unstalled cycle.
        if ((r_state != HALT) && !w_stall && (opcode_ex == OPC_SYSTEM)) begin
            w_state_nxt = HALT;
            w_wait_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // A stalled branch stays in EX and redirects on the first free cycle.
    assign w_redirect  = br_taken & ~w_stall & (r_state != HALT);
    assign w_fwd_allow = ~w_stall & ~w_timeout;

    assign stall_if = w_stall;
    assign stall_ex = w_stall;
    assign pc_sel   = w_redirect;
    assign flush_if = w_redirect;
    assign mem_err  = w_timeout;
    assign wb_kill  = w_timeout;
    assign halted   = (r_state == HALT);

    fwd_unit u_fwd_a (
        .i_wr_en   (reg_wr_wb),
        .i_rd      (rd_wb),
        .i_rs      (rs1_ex),
        .i_rs_used (uses_rs1(opcode_ex)),
        .i_allow   (w_fwd_allow),
        .o_fwd     (fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_wr_en   (reg_wr_wb),
        .i_rd      (rd_wb),
        .i_rs      (rs2_ex),
        .i_rs_used (uses_rs2(opcode_ex)),
        .i_allow   (w_fwd_allow),
        .o_fwd     (fwd_b)
    );

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state != HALT) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            if (w_stall && (r_state != HALT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl with
//               hand-computed expected values (MEM_TIMEOUT = 4, CNT_W = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] c_op     = 7'b0110011;
    localparam logic [6:0] c_opimm  = 7'b0010011;
    localparam logic [6:0] c_lui    = 7'b0110111;
    localparam logic [6:0] c_system = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode_ex = 7'd0;
    logic [4:0]  rs1_ex = 5'd0;
    logic [4:0]  rs2_ex = 5'd0;
    logic        br_taken = 1'b0;
    logic [4:0]  rd_wb = 5'd0;
    logic        reg_wr_wb = 1'b0;
    logic        mem_wb = 1'b0;
    logic        dmem_valid = 1'b0;
    logic        stall_if, stall_ex, flush_if, pc_sel, wb_kill;
    logic        fwd_a, fwd_b, mem_err, halted;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_ex  (opcode_ex),
        .rs1_ex     (rs1_ex),
        .rs2_ex     (rs2_ex),
        .br_taken   (br_taken),
        .rd_wb      (rd_wb),
        .reg_wr_wb  (reg_wr_wb),
        .mem_wb     (mem_wb),
        .dmem_valid (dmem_valid),
        .stall_if   (stall_if),
        .stall_ex   (stall_ex),
        .flush_if   (flush_if),
        .pc_sel     (pc_sel),
        .wb_kill    (wb_kill),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .mem_err    (mem_err),
        .halted     (halted),
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic br, input logic [4:0] rd, input logic wr,
                         input logic mem, input logic dv);
        opcode_ex = opc; rs1_ex = rs1; rs2_ex = rs2; br_taken = br;
        rd_wb = rd; reg_wr_wb = wr; mem_wb = mem; dmem_valid = dv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the stall/redirect/memory-error group as one packed vector
    // {stall_if, stall_ex, pc_sel, flush_if, mem_err, wb_kill, halted}.
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, stall_if, stall_ex, pc_sel, flush_if, mem_err, wb_kill, halted},
            {25'd0, exp});
    endtask

    initial begin
        // Reset with idle inputs: everything must be zero.
        drive(c_opimm, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("reset_ctl", 7'b0000000);
        chk("reset_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
        chk("reset_cyc", cyc_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: load result in WB completes immediately, forwarded onto A.
        drive(c_op, 5, 6, 0, 5, 1, 1, 1);
        chk_ctl("t1_ctl", 7'b0000000);
        chk("t1_fwd", {30'd0, fwd_a, fwd_b}, 32'd2);
        drive(c_op, 6, 5, 0, 5, 1, 0, 0);
        chk("t1_fwd_b", {30'd0, fwd_a, fwd_b}, 32'd1);
        drive(c_opimm, 6, 5, 0, 5, 1, 0, 0);
        chk("opimm_no_rs2", {30'd0, fwd_a, fwd_b}, 32'd0);
        drive(c_lui, 5, 5, 0, 5, 1, 0, 0);
        chk("lui_no_rs1", {30'd0, fwd_a, fwd_b}, 32'd0);
        drive(c_op, 5, 5, 0, 5, 0, 0, 0);
        chk("no_wr_no_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
        tick();
        drive(c_opimm, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("t1_still_run", 7'b0000000);

        // 4: x0 never forwards.
        drive(c_op, 0, 0, 0, 0, 1, 0, 0);
        chk("t4_x0", {30'd0, fwd_a, fwd_b}, 32'd0);

        // 2: memory never answers -> 4 stall cycles, then timeout abort.
        drive(c_op, 5, 5, 0, 5, 1, 1, 0);
        chk_ctl("t2_stall1", 7'b1100000);
        chk("t2_fwd_stalled", {30'd0, fwd_a, fwd_b}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk_ctl($sformatf("t2_stall%0d", i), 7'b1100000);
        end
        tick();
        drive(c_op, 5, 5, 0, 5, 1, 0, 0);
        chk_ctl("t2_timeout", 7'b0000110);
        chk("t2_fwd_killed", {30'd0, fwd_a, fwd_b}, 32'd0);
        tick();
        chk_ctl("t2_back_run", 7'b0000000);
        chk("t2_fwd_resume", {30'd0, fwd_a, fwd_b}, 32'd3);

        // 3: branch held during a memory stall, redirects on release only.
        drive(c_branch_opc(), 1, 2, 1, 0, 0, 1, 0);
        chk_ctl("t3_stall1", 7'b1100000);
        tick();
        chk_ctl("t3_stall2", 7'b1100000);
        tick();
        drive(c_branch_opc(), 1, 2, 1, 0, 0, 0, 1);
        chk_ctl("t3_release", 7'b0011000);
        tick();
        drive(c_opimm, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("t3_after", 7'b0000000);
        drive(c_opimm, 0, 0, 1, 0, 0, 0, 0);
        chk_ctl("t3_plain_branch", 7'b0011000);
        drive(c_opimm, 0, 0, 0, 0, 0, 0, 0);

        // 6: reset mid-wait (wait_cnt = 2) forgets the access.
        drive(c_op, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        chk_ctl("t6_waiting", 7'b1100000);
        rst = 1'b1;
        drive(c_opimm, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("t6_rst_ctl", 7'b0000000);
        chk("t6_rst_cyc", cyc_cnt, 32'd0);
        chk("t6_rst_stallc", stall_cnt, 32'd0);
        chk("t6_rst_flushc", flush_cnt, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_ctl("t6_run_after", 7'b0000000);
`ifdef PIPE_PERF_EN
        chk("t6_cyc10", cyc_cnt, 32'd10);
`else
        chk("t6_cyc_tied", cyc_cnt, 32'd0);
`endif
        chk("t6_stallc", stall_cnt, 32'd0);
        chk("t6_flushc", flush_cnt, 32'd0);

        // 5: SYSTEM in EX halts the core from the next cycle on.
        drive(c_system, 0, 0, 0, 0, 0, 0, 0);
        chk_ctl("t5_issue", 7'b0000000);
        tick();
        drive(c_op, 5, 5, 1, 5, 1, 0, 1);
        chk_ctl("t5_halt", 7'b1100001);
        chk("t5_fwd", {30'd0, fwd_a, fwd_b}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk_ctl("t5_halt_sticky", 7'b1100001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [6:0] c_branch_opc();
        return 7'b1100011;
    endfunction

endmodule
`default_nettype wire
